// File: rtl/hsv_pwm_fader.sv
// HSV colour-wheel fader: hue walks six sectors with a linear ramp per sector,
// and each RGB channel is driven by a period-latched PWM.
module hsv_pwm_fader #(
   parameter int CLK_HZ     = 12_000_000,
   parameter int CYCLE_MS   = 1000,
   parameter int PWM_BITS   = 8,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   output logic                RGB_R,
   output logic                RGB_G,
   output logic                RGB_B,
   output logic [2:0]          sector,
   output logic [PWM_BITS-1:0] level,
   output logic                cycle_done
);

   localparam longint CLOCKS_PER_REV = longint'(CLK_HZ) * longint'(CYCLE_MS) / 64'sd1000;
   localparam longint STEP_TICKS_L   = CLOCKS_PER_REV / (64'sd6 << PWM_BITS);
   localparam int     STEP_TICKS     = int'(STEP_TICKS_L);
   localparam int     TICK_W         = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

   localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(STEP_TICKS - 1);
   localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] PWM_LAST  = MAX - PWM_BITS'(1);
   localparam logic [PWM_BITS-1:0] ZERO      = {PWM_BITS{1'b0}};

   generate
      if (STEP_TICKS < 1) begin : g_bad_step
         $error("hsv_pwm_fader: STEP_TICKS must be at least 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      SEC_RED = 3'd0,
      SEC_YEL = 3'd1,
      SEC_GRN = 3'd2,
      SEC_CYN = 3'd3,
      SEC_BLU = 3'd4,
      SEC_MAG = 3'd5
   } sector_t;

   sector_t             state_r;
   sector_t             state_next_s;
   sector_t             succ_s;
   logic [PWM_BITS-1:0] level_r;
   logic [PWM_BITS-1:0] level_next_s;
   logic [TICK_W-1:0]   tick_r;
   logic [PWM_BITS-1:0] pwm_r;
   logic [PWM_BITS-1:0] duty_r_r;
   logic [PWM_BITS-1:0] duty_g_r;
   logic [PWM_BITS-1:0] duty_b_r;
   logic [PWM_BITS-1:0] tgt_r_s;
   logic [PWM_BITS-1:0] tgt_g_s;
   logic [PWM_BITS-1:0] tgt_b_s;
   logic                step_s;
   logic                illegal_s;
   logic                wrap_s;
   logic                cycle_done_r;
   logic                pin_r_r;
   logic                pin_g_r;
   logic                pin_b_r;

   assign step_s = en && (tick_r == TICK_LAST);

   // Sector successor, channel targets and ramp advance for the current state.
   always_comb begin
      state_next_s = state_r;
      level_next_s = level_r;
      succ_s       = SEC_RED;
      illegal_s    = 1'b0;
      wrap_s       = 1'b0;
      tgt_r_s      = ZERO;
      tgt_g_s      = ZERO;
      tgt_b_s      = ZERO;
      case (state_r)
         SEC_RED: begin succ_s = SEC_YEL; tgt_r_s = MAX;           tgt_g_s = level_r;       end
         SEC_YEL: begin succ_s = SEC_GRN; tgt_r_s = MAX - level_r; tgt_g_s = MAX;           end
         SEC_GRN: begin succ_s = SEC_CYN; tgt_g_s = MAX;           tgt_b_s = level_r;       end
         SEC_CYN: begin succ_s = SEC_BLU; tgt_g_s = MAX - level_r; tgt_b_s = MAX;           end
         SEC_BLU: begin succ_s = SEC_MAG; tgt_r_s = level_r;       tgt_b_s = MAX;           end
         SEC_MAG: begin succ_s = SEC_RED; tgt_r_s = MAX;           tgt_b_s = MAX - level_r; end
         default: begin illegal_s = 1'b1; end
      endcase
      // Corrupted sector encodings recover to the start of the wheel.
      if (illegal_s) begin
         state_next_s = SEC_RED;
         level_next_s = ZERO;
      end else if (step_s) begin
         if (level_r == MAX) begin
            level_next_s = ZERO;
            state_next_s = succ_s;
            wrap_s       = (state_r == SEC_MAG);
         end else begin
            level_next_s = level_r + PWM_BITS'(1);
         end
      end else begin
         state_next_s = state_r;
         level_next_s = level_r;
      end
   end

   // Sector state, ramp level, step timer and wrap pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= SEC_RED;
         level_r      <= ZERO;
         tick_r       <= {TICK_W{1'b0}};
         cycle_done_r <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         level_r      <= level_next_s;
         cycle_done_r <= wrap_s;
         if (en) begin
            tick_r <= (tick_r == TICK_LAST) ? {TICK_W{1'b0}} : tick_r + TICK_W'(1);
         end else begin
            tick_r <= tick_r;
         end
      end
   end

   // PWM period counter, period-start duty latch and registered pins.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_r    <= ZERO;
         duty_r_r <= ZERO;
         duty_g_r <= ZERO;
         duty_b_r <= ZERO;
         pin_r_r  <= ACTIVE_LOW;
         pin_g_r  <= ACTIVE_LOW;
         pin_b_r  <= ACTIVE_LOW;
      end else begin
         pwm_r   <= (pwm_r == PWM_LAST) ? ZERO : pwm_r + PWM_BITS'(1);
         pin_r_r <= (pwm_r < duty_r_r) ^ ACTIVE_LOW;
         pin_g_r <= (pwm_r < duty_g_r) ^ ACTIVE_LOW;
         pin_b_r <= (pwm_r < duty_b_r) ^ ACTIVE_LOW;
         if (pwm_r == ZERO) begin
            duty_r_r <= tgt_r_s;
            duty_g_r <= tgt_g_s;
            duty_b_r <= tgt_b_s;
         end else begin
            duty_r_r <= duty_r_r;
            duty_g_r <= duty_g_r;
            duty_b_r <= duty_b_r;
         end
      end
   end

   assign sector     = state_r;
   assign level      = level_r;
   assign cycle_done = cycle_done_r;
   assign RGB_R      = pin_r_r;
   assign RGB_G      = pin_g_r;
   assign RGB_B      = pin_b_r;

endmodule

// File: tb/tb_hsv_pwm_fader.sv
// Scoreboard bench: three faders (active-low, active-high, four clocks per step)
// share random rst/en and are checked every clock against a hue-position model.
module tb_hsv_pwm_fader;

   localparam int MAXV = 15;
   localparam int NLVL = 16;
   localparam int REV  = 6 * NLVL;

   typedef struct packed {
      logic [2:0] sec;
      logic [3:0] lvl;
      logic [2:0] rgb;
      logic       cd;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [2:0] r_pin, g_pin, b_pin, cd;
   logic [2:0][2:0] sec;
   logic [2:0][3:0] lvl;

   exp_t q0[$], q1[$], q2[$];

   int m_tick[3], m_pos[3], m_pwm[3], m_cd[3];
   int m_duty[3][3], m_pin[3][3];

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   hsv_pwm_fader #(.CLK_HZ(96),  .CYCLE_MS(1000), .PWM_BITS(4), .ACTIVE_LOW(1'b1)) d0 (
      .clk(clk), .rst(rst), .en(en), .RGB_R(r_pin[0]), .RGB_G(g_pin[0]), .RGB_B(b_pin[0]),
      .sector(sec[0]), .level(lvl[0]), .cycle_done(cd[0]));
   hsv_pwm_fader #(.CLK_HZ(96),  .CYCLE_MS(1000), .PWM_BITS(4), .ACTIVE_LOW(1'b0)) d1 (
      .clk(clk), .rst(rst), .en(en), .RGB_R(r_pin[1]), .RGB_G(g_pin[1]), .RGB_B(b_pin[1]),
      .sector(sec[1]), .level(lvl[1]), .cycle_done(cd[1]));
   hsv_pwm_fader #(.CLK_HZ(384), .CYCLE_MS(1000), .PWM_BITS(4), .ACTIVE_LOW(1'b1)) d2 (
      .clk(clk), .rst(rst), .en(en), .RGB_R(r_pin[2]), .RGB_G(g_pin[2]), .RGB_B(b_pin[2]),
      .sector(sec[2]), .level(lvl[2]), .cycle_done(cd[2]));

   function automatic int active_low_of(int i);
      return (i == 1) ? 0 : 1;
   endfunction

   function automatic int step_ticks_of(int i);
      return (i == 2) ? 4 : 1;
   endfunction

   // Red brightness as a function of sector: full over sectors 5 and 0, ramps down
   // in 1, off in 2 and 3, ramps up in 4. Green and blue are the same curve
   // shifted by two and four sectors.
   function automatic int red_curve(int s, int l);
      case ((s + 1) % 6)
         0, 1:    return MAXV;
         2:       return MAXV - l;
         5:       return l;
         default: return 0;
      endcase
   endfunction

   function automatic int target(int pos, int ch);
      return red_curve((pos / NLVL - 2 * ch + 6) % 6, pos % NLVL);
   endfunction

   task automatic model_edge(int i, logic r, logic e);
      int al;
      int st;
      bit step;
      al = active_low_of(i);
      st = step_ticks_of(i);
      if (r) begin
         m_tick[i] = 0; m_pos[i] = 0; m_pwm[i] = 0; m_cd[i] = 0;
         for (int c = 0; c < 3; c++) begin
            m_duty[i][c] = 0;
            m_pin[i][c]  = al;
         end
      end else begin
         step = e && (m_tick[i] == st - 1);
         for (int c = 0; c < 3; c++) begin
            m_pin[i][c] = ((m_pwm[i] < m_duty[i][c]) ? 1 : 0) ^ al;
            if (m_pwm[i] == 0) m_duty[i][c] = target(m_pos[i], c);
         end
         m_pwm[i] = (m_pwm[i] + 1) % MAXV;
         if (e) m_tick[i] = (m_tick[i] + 1) % st;
         m_cd[i] = (step && m_pos[i] == REV - 1) ? 1 : 0;
         if (step) m_pos[i] = (m_pos[i] + 1) % REV;
      end
   endtask

   task automatic push_expected(int i);
      exp_t x;
      x.sec = 3'(m_pos[i] / NLVL);
      x.lvl = 4'(m_pos[i] % NLVL);
      x.rgb = {1'(m_pin[i][2]), 1'(m_pin[i][1]), 1'(m_pin[i][0])};
      x.cd  = 1'(m_cd[i]);
      case (i)
         0:       q0.push_back(x);
         1:       q1.push_back(x);
         default: q2.push_back(x);
      endcase
   endtask

   task automatic drive(logic r, logic e);
      @(negedge clk);
      rst = r;
      en  = e;
      for (int i = 0; i < 3; i++) begin
         model_edge(i, r, e);
         push_expected(i);
      end
   endtask

   // Monitor: after each active edge, pop one expectation per fader and compare.
   initial begin
      exp_t want;
      exp_t got;
      bit   have;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         for (int i = 0; i < 3; i++) begin
            have = 1'b0;
            case (i)
               0:       if (q0.size() > 0) begin want = q0.pop_front(); have = 1'b1; end
               1:       if (q1.size() > 0) begin want = q1.pop_front(); have = 1'b1; end
               default: if (q2.size() > 0) begin want = q2.pop_front(); have = 1'b1; end
            endcase
            if (have) begin
               got = {sec[i], lvl[i], {b_pin[i], g_pin[i], r_pin[i]}, cd[i]};
               tests_run++;
               if (got !== want) begin
                  tests_failed++;
                  $display("FAIL dut%0d cycle %0d: got sector=%0d level=%0d bgr=%b cycle_done=%b, expected sector=%0d level=%0d bgr=%b cycle_done=%b",
                           i, cyc, got.sec, got.lvl, got.rgb, got.cd, want.sec, want.lvl, want.rgb, want.cd);
               end
            end
         end
      end
   end

   // Stimulus: reset hold, frozen hue, free-running revolutions, then random rst/en.
   initial begin
      rst = 1'b1;
      en  = 1'b0;
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b0);
      for (int k = 0; k < 45; k++) drive(1'b0, 1'b0);
      for (int k = 0; k < 420; k++) drive(1'b0, 1'b1);
      for (int k = 0; k < 600; k++) drive(1'b0, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 2500; k++) begin
         drive(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 9) != 0));
      end
      @(posedge clk);
      #2;
      tests_run++;
      if (q0.size() + q1.size() + q2.size() != 0) begin
         tests_failed++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0",
                  q0.size() + q1.size() + q2.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
